ram_dp_core: RTL and testbench

Synchronous dual-port RAM. It is the design under test driven by the RAM write and read agents, and it has independent write and read ports on one clock. After every reset it clears its whole array through a hardware init sweep. Reads have a one-cycle registered latency and a valid strobe, which the read monitor and scoreboard consume.

---
 rtl/ram_dp_core.sv | 115 +++++++++++
 tb/tb_ram_dp_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_core.sv
// Dual-port RAM with a hardware zero-fill sweep after every reset.
// One write port and one registered read port share a single clock.
module ram_dp_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  access_err,
    output logic                  state_o
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   init_ptr_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    rd_valid_q;
    logic                    busy_q;
    logic                    access_err_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_fire;
    logic                    rd_fire;
    logic                    collide;
    logic [DATA_WIDTH-1:0]   rd_word_d;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Requests are single-cycle strobes sampled at posedge; there is no ready.
    // While busy they are dropped and flagged; a read answers one cycle later
    // with rd_valid, and a same-address write on that edge is forwarded.
    always_comb begin
        wr_fire   = (state_q == ST_READY) && wr_enb;
        rd_fire   = (state_q == ST_READY) && rd_enb;
        collide   = wr_fire && rd_fire && (wr_addr == rd_addr);
        rd_word_d = collide ? data_in : mem_q[rd_addr];
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = data_in;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_ptr_q;
            mem_wdata = '0;
        end else begin
            mem_we    = wr_fire;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b1;
            access_err_q <= 1'b0;
        end else begin
            rd_valid_q   <= 1'b0;
            access_err_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    access_err_q <= wr_enb | rd_enb;
                    init_ptr_q   <= init_ptr_q + 1'b1;
                    if (init_ptr_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    rd_valid_q <= rd_fire;
                    if (rd_fire) begin
                        data_out_q <= rd_word_d;
                    end
                end
            endcase
        end
    end

    // Array is deliberately outside the reset domain; the sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out   = data_out_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = busy_q;
    assign access_err = access_err_q;
    assign state_o    = state_q;

`ifndef SYNTHESIS
    a_valid_not_busy : assert property (@(posedge clk) disable iff (!rst)
        rd_valid |-> !busy);
    a_err_excl_valid : assert property (@(posedge clk) disable iff (!rst)
        !(access_err && rd_valid));
`endif

endmodule

// File: tb/tb_ram_dp_core.sv
// Bench for ram_dp_core: vector table, hand-written corner sequences and
// random traffic, all compared against a behavioural model of the RAM.
module tb_ram_dp_core;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_enb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] data_in;
  logic          rd_enb;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          busy;
  logic          access_err;
  logic          state_o;

  int checks   = 0;
  int failures = 0;

  ram_dp_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_enb     (wr_enb),
    .wr_addr    (wr_addr),
    .data_in    (data_in),
    .rd_enb     (rd_enb),
    .rd_addr    (rd_addr),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .access_err (access_err),
    .state_o    (state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural model: an array, an edge counter since reset, expected outputs
  logic [DW-1:0] m_mem [DEPTH];
  int            m_edges;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_err;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_edges = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_edge(input logic wr, input logic [AW-1:0] wa,
                                     input logic [DW-1:0] d, input logic rd,
                                     input logic [AW-1:0] ra);
    if (m_edges < DEPTH) begin
      m_err   = wr | rd;
      m_valid = 1'b0;
    end else begin
      m_err   = 1'b0;
      m_valid = rd;
      if (rd) m_data = (wr && wa == ra) ? d : m_mem[ra];
      if (wr) m_mem[wa] = d;
    end
    m_edges++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".busy"},  32'(busy),       32'(m_edges < DEPTH));
    check({tag, ".state"}, 32'(state_o),    32'(m_edges >= DEPTH));
    check({tag, ".valid"}, 32'(rd_valid),   32'(m_valid));
    check({tag, ".err"},   32'(access_err), 32'(m_err));
    check({tag, ".data"},  32'(data_out),   32'(m_data));
  endtask

  // driver: apply one request set across one posedge, check at the next negedge
  task automatic cycle(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic rd, input logic [AW-1:0] ra, input string tag);
    wr_enb  = wr;
    wr_addr = wa;
    data_in = d;
    rd_enb  = rd;
    rd_addr = ra;
    @(posedge clk);
    model_edge(wr, wa, d, rd, ra);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic          rd;
    logic [AW-1:0] ra;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    logic          wr;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;

    vecs[0]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  1'b0, 8'h00};
    vecs[1]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'hA5};
    vecs[2]  = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0,  1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 4'd7,  8'h3C, 1'b1, 4'd7,  1'b1, 8'h3C};
    vecs[4]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  1'b1, 8'h3C};
    vecs[5]  = '{1'b1, 4'd5,  8'h77, 1'b1, 4'd3,  1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  1'b1, 8'h77};
    vecs[7]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h77};
    vecs[8]  = '{1'b1, 4'd15, 8'hFE, 1'b1, 4'd0,  1'b1, 8'h00};
    vecs[9]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'hFE};
    vecs[10] = '{1'b1, 4'd0,  8'h01, 1'b1, 4'd0,  1'b1, 8'h01};
    vecs[11] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h01};

    rst = 1'b0; wr_enb = 1'b0; wr_addr = '0; data_in = '0; rd_enb = 1'b0; rd_addr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model("reset");
    rst = 1'b1;

    // clean init sweep: count edges until busy drops
    edges = 0;
    while (busy && edges < 40) begin
      cycle(1'b0, '0, '0, 1'b0, '0, "init");
      edges++;
    end
    check("init_len", 32'(edges), 32'(DEPTH));

    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, '0, 1'b1, AW'(i), "zero_rd");
      check("zero_rd_valid", 32'(rd_valid), 32'd1);
      check("zero_rd_data",  32'(data_out), 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].wr, vecs[i].wa, vecs[i].d, vecs[i].rd, vecs[i].ra, "vec");
      check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_data", i),  32'(data_out), 32'(vecs[i].ed));
    end

    for (int i = 0; i < DEPTH; i++) cycle(1'b1, AW'(i), DW'(8'h10 + i), 1'b0, '0, "b2b_wr");
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, '0, 1'b1, AW'(i), "b2b_rd");
      check("b2b_valid", 32'(rd_valid), 32'd1);
      check("b2b_data",  32'(data_out), 32'(8'h10 + i));
    end

    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      cycle(wr, wa, DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ra, "rand");
    end

    // reset during an in-flight read
    cycle(1'b1, 4'd3, 8'h13, 1'b0, '0, "mr_wr");
    cycle(1'b0, '0, '0, 1'b1, 4'd3, "mr_rd");
    check("mr_rd_data", 32'(data_out), 32'h13);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("mr_valid", 32'(rd_valid), 32'd0);
    check("mr_data",  32'(data_out), 32'd0);
    check("mr_busy",  32'(busy),     32'd1);
    @(negedge clk);
    rd_enb = 1'b0;
    rst    = 1'b1;

    // requests during the sweep are dropped and flagged one cycle each
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 2)       cycle(1'b1, 4'd2, 8'hFF, 1'b0, '0,   "init_acc");
      else if (k == 5)  cycle(1'b1, 4'd9, 8'h55, 1'b1, 4'd9, "init_acc");
      else if (k == 15) cycle(1'b0, '0,   '0,    1'b1, 4'd2, "init_acc");
      else              cycle(1'b0, '0,   '0,    1'b0, '0,   "init_acc");
      if (k == 2) check("init_err_pulse", 32'(access_err), 32'd1);
      if (k == 3) check("init_err_clear", 32'(access_err), 32'd0);
    end
    cycle(1'b0, '0, '0, 1'b1, 4'd2, "post_rd2");
    check("post_rd2_data", 32'(data_out), 32'd0);
    cycle(1'b0, '0, '0, 1'b1, 4'd3, "post_rd3");
    check("post_rd3_data", 32'(data_out), 32'd0);
    cycle(1'b0, '0, '0, 1'b1, 4'd9, "post_rd9");
    check("post_rd9_data", 32'(data_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
